// File: rtl/cmd_issuer.sv
// rtl/cmd_issuer.sv - base-station command issuer: GO/STOP request to UART 8N1 byte on TX
// A STOP arriving mid-frame is parked in a one-deep slot and sent right after the current frame.
module cmd_issuer #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_go,
    input  logic       send_stop,
    input  logic [5:0] dest_in,
    output logic       TX,
    output logic       busy,
    output logic       cmd_sent,
    output logic [7:0] last_cmd
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_DIV - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            stop_pend;
    logic            bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= 8'h00;
            stop_pend <= 1'b0;
            TX        <= 1'b1;
            busy      <= 1'b0;
            cmd_sent  <= 1'b0;
            last_cmd  <= 8'h00;
        end else begin
            // Registered one cycle early so the pulse lands in the last stop-bit cycle.
            cmd_sent <= (state == S_STOP) && (baud_cnt == BAUD_PRE);

            if (state != S_IDLE && send_stop)
                stop_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (send_stop || send_go) begin
                        shift    <= send_stop ? 8'h00 : {2'b01, dest_in};
                        last_cmd <= send_stop ? 8'h00 : {2'b01, dest_in};
                        state    <= S_START;
                        TX       <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                        TX       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                            TX    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            TX      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (stop_pend || send_stop) begin
                            state     <= S_START;
                            shift     <= 8'h00;
                            last_cmd  <= 8'h00;
                            TX        <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    TX    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_issuer.sv
// tb/tb_cmd_issuer.sv - directed table-driven bench for cmd_issuer
module tb_cmd_issuer;

    localparam int B = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       send_go, send_stop;
    logic [5:0] dest_in;
    logic       TX, busy, cmd_sent;
    logic [7:0] last_cmd;

    logic       go2, stop2;
    logic [5:0] dest2;
    logic       tx2, busy2, sent2;
    logic [7:0] last2;

    int total = 0;
    int bad   = 0;

    cmd_issuer #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .send_go(send_go), .send_stop(send_stop),
        .dest_in(dest_in), .TX(TX), .busy(busy), .cmd_sent(cmd_sent),
        .last_cmd(last_cmd)
    );

    cmd_issuer #(.BAUD_DIV(2604)) dut2 (
        .clk(clk), .rst(rst), .send_go(go2), .send_stop(stop2),
        .dest_in(dest2), .TX(tx2), .busy(busy2), .cmd_sent(sent2),
        .last_cmd(last2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       go;
        logic       stop;
        logic [5:0] dest;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is #1 into an idle cycle (cycle 0); returns #1 into cycle 1.
    task automatic request(input logic go, input logic stop, input logic [5:0] dest,
                           input logic [7:0] exp);
        send_go   = go;
        send_stop = stop;
        dest_in   = dest;
        chk("busy in request cycle", busy, 1'b0);
        tick();
        send_go   = 1'b0;
        send_stop = 1'b0;
        chk("last_cmd after accept", last_cmd, exp);
    endtask

    // Entry at #1 into cycle 1 of a frame; exit at #1 into cycle 41.
    task automatic check_frame(input logic [7:0] b, input bit follow,
                               input int inj_cycle, input int inj_len,
                               input logic inj_go, input logic inj_stop,
                               input logic [5:0] inj_dest);
        logic exp_tx;
        for (int k = 1; k <= 10 * B; k++) begin
            if (k == inj_cycle) begin
                send_go   = inj_go;
                send_stop = inj_stop;
                dest_in   = inj_dest;
            end
            if (k == inj_cycle + inj_len) begin
                send_go   = 1'b0;
                send_stop = 1'b0;
            end
            if (k <= B)
                exp_tx = 1'b0;
            else if (k <= 9 * B)
                exp_tx = b[(k - B - 1) / B];
            else
                exp_tx = 1'b1;
            chk($sformatf("tx %02h c%0d", b, k), TX, exp_tx);
            chk($sformatf("busy %02h c%0d", b, k), busy, 1'b1);
            chk($sformatf("cmd_sent %02h c%0d", b, k), cmd_sent, k == 10 * B);
            tick();
        end
        send_go   = 1'b0;
        send_stop = 1'b0;
        if (!follow) begin
            chk("busy after frame", busy, 1'b0);
            chk("tx idle after frame", TX, 1'b1);
            chk("cmd_sent after frame", cmd_sent, 1'b0);
        end
    endtask

    initial begin
        int pulses;
        int n;
        bit tx_low;

        vecs[0] = '{go: 1'b1, stop: 1'b0, dest: 6'h2A, exp: 8'h6A};
        vecs[1] = '{go: 1'b0, stop: 1'b1, dest: 6'h15, exp: 8'h00};
        vecs[2] = '{go: 1'b1, stop: 1'b1, dest: 6'h3F, exp: 8'h00};
        vecs[3] = '{go: 1'b1, stop: 1'b0, dest: 6'h3F, exp: 8'h7F};
        vecs[4] = '{go: 1'b1, stop: 1'b0, dest: 6'h00, exp: 8'h40};

        rst = 1'b1; send_go = 1'b0; send_stop = 1'b0; dest_in = 6'h00;
        go2 = 1'b0; stop2 = 1'b0; dest2 = 6'h00;
        tick();
        tick();
        rst = 1'b0;
        chk("reset TX", TX, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset cmd_sent", cmd_sent, 1'b0);
        chk("reset last_cmd", last_cmd, 8'h00);
        tick();

        for (int i = 0; i < 5; i++) begin
            request(vecs[i].go, vecs[i].stop, vecs[i].dest, vecs[i].exp);
            check_frame(vecs[i].exp, 1'b0, 0, 0, 1'b0, 1'b0, 6'h00);
        end

        // GO while busy is dropped
        request(1'b1, 1'b0, 6'h2A, 8'h6A);
        check_frame(8'h6A, 1'b0, 10, 1, 1'b1, 1'b0, 6'h05);
        chk("last_cmd after ignored GO", last_cmd, 8'h6A);

        // STOP held 3 cycles mid-frame collapses into one back-to-back STOP frame
        request(1'b1, 1'b0, 6'h11, 8'h51);
        check_frame(8'h51, 1'b1, 20, 3, 1'b0, 1'b1, 6'h11);
        chk("last_cmd chained stop", last_cmd, 8'h00);
        check_frame(8'h00, 1'b0, 0, 0, 1'b0, 1'b0, 6'h00);

        // STOP arriving in the very last stop-bit cycle still chains
        request(1'b1, 1'b0, 6'h07, 8'h47);
        check_frame(8'h47, 1'b1, 40, 1, 1'b0, 1'b1, 6'h07);
        check_frame(8'h00, 1'b0, 0, 0, 1'b0, 1'b0, 6'h00);

        // dest_in churn mid-frame does not disturb the byte in flight
        request(1'b1, 1'b0, 6'h2A, 8'h6A);
        check_frame(8'h6A, 1'b0, 12, 1, 1'b0, 1'b0, 6'h15);

        // request in the first idle cycle after a frame is accepted
        request(1'b0, 1'b1, 6'h00, 8'h00);
        check_frame(8'h00, 1'b0, 0, 0, 1'b0, 1'b0, 6'h00);

        // reset at cycle 15 aborts the frame
        request(1'b1, 1'b0, 6'h2A, 8'h6A);
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort TX", TX, 1'b1);
        chk("abort busy", busy, 1'b0);
        chk("abort last_cmd", last_cmd, 8'h00);
        pulses = 0;
        tx_low = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (cmd_sent) pulses++;
            if (!TX) tx_low = 1'b1;
            tick();
        end
        chk("abort no cmd_sent", pulses, 0);
        chk("abort TX stays idle", tx_low, 1'b0);
        request(1'b1, 1'b0, 6'h01, 8'h41);
        check_frame(8'h41, 1'b0, 0, 0, 1'b0, 1'b0, 6'h00);

        // full-rate divider: frame occupies 10*2604 cycles
        go2 = 1'b1;
        dest2 = 6'h2A;
        tick();
        go2 = 1'b0;
        n = 0;
        pulses = 0;
        while (busy2 && n < 30000) begin
            if (sent2) pulses++;
            tick();
            n++;
        end
        chk("smoke frame length", n, 26040);
        chk("smoke cmd_sent count", pulses, 1);
        chk("smoke last_cmd", last2, 8'h6A);
        chk("smoke TX idle", tx2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
